// File: rtl/data_ram_pipe_if.sv
// Request/response bus between the MEM stage and data_ram_pipe.
// Handshake: a request transfers on a rising clk edge where req_i=1 and
// ready_o=1; with ready_o=0 the request fields are ignored. Every
// transferred request produces exactly one rsp_valid_o cycle a fixed
// number of cycles later. Responses cannot be stalled.
interface data_ram_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  req_i;
  logic                  we_i;
  logic [LANES-1:0]      sel_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  ready_o;
  logic                  rsp_valid_o;
  logic                  rsp_we_o;
  logic                  rsp_err_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, sel_i, addr_i, data_i,
    input  ready_o, rsp_valid_o, rsp_we_o, rsp_err_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, sel_i, addr_i, data_i,
    output ready_o, rsp_valid_o, rsp_we_o, rsp_err_o, rdata_o
  );
endinterface

// File: rtl/data_ram_pipe.sv
// Byte-lane data memory for the MEM stage with a fixed-latency response
// pipeline and an optional zero sweep of the array after reset.
module data_ram_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH_LOG2     = 9,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           clk,
  input  logic           rst,        // asynchronous, active low
  data_ram_pipe_if.slave bus,
  output logic           dbg_state   // 0 = INIT sweep, 1 = RUN
);
  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_LOG2 = $clog2(LANES);
  localparam int DEPTH     = 2 ** DEPTH_LOG2;
  localparam int IDX_TOP   = DEPTH_LOG2 + LANE_LOG2;

  localparam logic [LANES-1:0] SEL_ALL = '1;
  localparam logic [LANES-1:0] SEL_LO  = SEL_ALL >> (LANES / 2);
  localparam logic [LANES-1:0] SEL_HI  = SEL_ALL << (LANES / 2);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   clr_cnt;
  logic                    ready;
  logic                    clr_we;
  logic                    acc;
  logic                    oor;
  logic                    sel_ok;
  logic                    req_err;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [LANES-1:0]        lane_we;
  logic [DATA_WIDTH-1:0]   lane_mask;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   s0_data;
  logic [READ_LATENCY-1:0] stg_valid;
  logic [READ_LATENCY-1:0] stg_we;
  logic [READ_LATENCY-1:0] stg_err;
  logic [DATA_WIDTH-1:0]   stg_data [READ_LATENCY];
  logic                    unused_addr_lsb;

  // Byte offset within a word does not matter: the lane select decides.
  assign unused_addr_lsb = ^bus.addr_i[LANE_LOG2-1:0];
  assign word_idx        = bus.addr_i[IDX_TOP-1:LANE_LOG2];
  assign oor             = (bus.addr_i >> IDX_TOP) != '0;
  assign acc             = bus.req_i & ready;
  assign req_err         = oor | ~sel_ok;

  // Legal selects: one lane, the aligned low or high half, or all lanes.
  always_comb begin
    sel_ok = (bus.sel_i == SEL_ALL) || (bus.sel_i == SEL_LO) || (bus.sel_i == SEL_HI);
    for (int k = 0; k < LANES; k++) begin
      if (bus.sel_i == (LANES'(1) << k)) sel_ok = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RESET_STATE;
    else      state_q <= state_d;
  end

  // FSM next state: leave INIT once the last word has been cleared.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && clr_cnt == '1) state_d = ST_RUN;
  end

  // FSM outputs: accept requests only in RUN, sweep only in INIT.
  always_comb begin
    ready  = (state_q == ST_RUN);
    clr_we = (state_q == ST_INIT);
  end

  // Sweep index, one word per INIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + DEPTH_LOG2'(1);
  end

  // Write port: the sweep owns the array in INIT, requests own it in RUN.
  always_comb begin
    wr_idx  = word_idx;
    wr_data = bus.data_i;
    lane_we = '0;
    if (clr_we) begin
      wr_idx  = clr_cnt;
      wr_data = '0;
      lane_we = '1;
    end else if (acc && bus.we_i && !req_err) begin
      lane_we = bus.sel_i;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // One byte bank per lane; contents survive reset.
    always_ff @(posedge clk) begin
      if (lane_we[k]) mem[wr_idx] <= wr_data[8*k +: 8];
    end

    assign rd_word[8*k +: 8] = mem[word_idx];
  end

  // Expand the lane select into a byte mask and form the stage-0 read data.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < LANES; k++) lane_mask[8*k +: 8] = {8{bus.sel_i[k]}};
    s0_data = '0;
    if (acc && !bus.we_i && !req_err) s0_data = rd_word & lane_mask;
  end

  // Response pipeline; idle stages carry all zeros so outputs are clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid <= '0;
      stg_we    <= '0;
      stg_err   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) stg_data[i] <= '0;
    end else begin
      stg_valid[0] <= acc;
      stg_we[0]    <= acc & bus.we_i;
      stg_err[0]   <= acc & req_err;
      stg_data[0]  <= s0_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_we[i]    <= stg_we[i-1];
        stg_err[i]   <= stg_err[i-1];
        stg_data[i]  <= stg_data[i-1];
      end
    end
  end

  assign bus.ready_o     = ready;
  assign bus.rsp_valid_o = stg_valid[READ_LATENCY-1];
  assign bus.rsp_we_o    = stg_we[READ_LATENCY-1];
  assign bus.rsp_err_o   = stg_err[READ_LATENCY-1];
  assign bus.rdata_o     = stg_data[READ_LATENCY-1];
  assign dbg_state       = state_q;
endmodule
